// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller is the master: it reads the decoded instruction fields and
// status flags, and drives the enables, mux selects and ALU control.
interface mc_control_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_dbg
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit: Moore FSM sequencing
// fetch/decode/execute/memory/writeback, stalling on mem_ready.
module mc_control_fsm #(
    parameter int p_funct_check = 1
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_reg;
    state_t state_next;

    // Ungated decode of the current state; write enables and illegal_op are
    // masked by reset below so nothing commits while reset is high.
    logic       pcen_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       illegal_raw;
    logic       iord_c;
    logic       memtoreg_c;
    logic       regdst_c;
    logic       alusrca_c;
    logic [1:0] alusrcb_c;
    logic [1:0] pcsrc_c;
    logic [2:0] alucontrol_c;

    // State register; reset pulls the machine back to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and Moore output decode (mem_ready/zero qualify a few enables).
    always_comb begin
        state_next   = state_reg;
        pcen_raw     = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        iord_c       = 1'b0;
        memtoreg_c   = 1'b0;
        regdst_c     = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        alucontrol_c = ALU_ADD;

        case (state_reg)
            S_FETCH: begin
                // PC+4 computed while the instruction is read; both commit
                // only on the cycle the memory completes.
                alusrcb_c   = 2'b01;
                irwrite_raw = bus.mem_ready;
                pcen_raw    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC+(imm<<2) is precomputed into ALUOut here.
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal_raw = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg_c   = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe held through the completing cycle.
                iord_c       = 1'b1;
                memwrite_raw = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca_c  = 1'b1;
                state_next = S_ALUWB;
                case (bus.funct)
                    FN_ADD: alucontrol_c = ALU_ADD;
                    FN_SUB: alucontrol_c = ALU_SUB;
                    FN_AND: alucontrol_c = ALU_AND;
                    FN_OR:  alucontrol_c = ALU_OR;
                    FN_SLT: alucontrol_c = ALU_SLT;
                    default: begin
                        // Unknown funct either traps or falls back to add.
                        if (p_funct_check != 0) begin
                            illegal_raw = 1'b1;
                            state_next  = S_FETCH;
                        end
                    end
                endcase
            end
            S_ALUWB: begin
                regdst_c     = 1'b1;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                pcen_raw     = bus.zero;
                state_next   = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca_c  = 1'b1;
                alusrcb_c  = 2'b10;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c    = 2'b10;
                pcen_raw   = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.pcen       = pcen_raw & ~reset;
    assign bus.irwrite    = irwrite_raw & ~reset;
    assign bus.regwrite   = regwrite_raw & ~reset;
    assign bus.memwrite   = memwrite_raw & ~reset;
    assign bus.illegal_op = illegal_raw & ~reset;
    assign bus.iord       = iord_c;
    assign bus.memtoreg   = memtoreg_c;
    assign bus.regdst     = regdst_c;
    assign bus.alusrca    = alusrca_c;
    assign bus.alusrcb    = alusrcb_c;
    assign bus.pcsrc      = pcsrc_c;
    assign bus.alucontrol = alucontrol_c;
    assign bus.state_dbg  = state_reg;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: the stimulus thread pushes the expected
// output vector for each cycle; the monitor pops and compares on negedge.
module tb_mc_control_fsm;
    logic clk;
    logic reset;

    mc_control_fsm_if bus ();

    mc_control_fsm #(.p_funct_check(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       ill;
    } exp_t;

    // Hand-written expected vectors:
    // st, pcen, irw, regw, memw, iord, m2r, rdst, asa, asb, pcs, aluc, ill
    localparam exp_t E_FETCH1  = {4'd0,  8'b1100_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_FETCH0  = {4'd0,  8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_DECODE  = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_DECILL  = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam exp_t E_MEMADR  = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_MEMRD   = {4'd3,  8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_MEMWB   = {4'd4,  8'b0010_0100, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_MEMWR   = {4'd5,  8'b0001_1000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_EXSUB   = {4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0};
    localparam exp_t E_EXILL   = {4'd6,  8'b0000_0001, 2'b00, 2'b00, 3'b010, 1'b1};
    localparam exp_t E_ALUWB   = {4'd7,  8'b0010_0010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_BEQ_Z1  = {4'd8,  8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam exp_t E_BEQ_Z0  = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam exp_t E_ADDIEX  = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_ADDIWB  = {4'd10, 8'b0010_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam exp_t E_JUMP    = {4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_BQ = 6'b000100;
    localparam logic [5:0] OP_AI = 6'b001000;
    localparam logic [5:0] OP_J  = 6'b000010;
    localparam logic [5:0] OP_XX = 6'b111111;
    localparam logic [5:0] FN_SB = 6'b100010;
    localparam logic [5:0] FN_XX = 6'b000111;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    // One cycle of stimulus: drive inputs, queue the expected outputs.
    task automatic step(input string nm, input logic r, input logic [5:0] o,
                        input logic [5:0] f, input logic z, input logic mr,
                        input exp_t e);
        reset         = r;
        bus.op        = o;
        bus.funct     = f;
        bus.zero      = z;
        bus.mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t  e;
                exp_t  a;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {bus.state_dbg, bus.pcen, bus.irwrite, bus.regwrite,
                      bus.memwrite, bus.iord, bus.memtoreg, bus.regdst,
                      bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                      bus.illegal_op};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s cyc%0d actual=%05h (state %0d) required=%05h (state %0d)",
                             nm, cyc, a, a.st, e, e.st);
                end
                checks++;
                if (bus.regwrite === 1'b1 && bus.memwrite === 1'b1) begin
                    errors++;
                    $display("FAIL excl_write cyc%0d actual regwrite=1 memwrite=1 required at most one", cyc);
                end
                $display("cyc%0d %s state=%0d", cyc, nm, a.st);
            end
            cyc++;
        end
    end

    initial begin
        reset         = 1'b1;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, enables forced low even with mem_ready high.
        step("reset",      1'b1, OP_R, 6'd0, 1'b0, 1'b1, E_FETCH0);

        // lw with memory always ready: 0,1,2,3,4 then back to 0.
        step("lw_fetch",   1'b0, OP_LW, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("lw_decode",  1'b0, OP_LW, 6'd0, 1'b0, 1'b1, E_DECODE);
        step("lw_memadr",  1'b0, OP_LW, 6'd0, 1'b0, 1'b1, E_MEMADR);
        step("lw_memrd",   1'b0, OP_LW, 6'd0, 1'b0, 1'b1, E_MEMRD);
        step("lw_memwb",   1'b0, OP_LW, 6'd0, 1'b0, 1'b1, E_MEMWB);

        // sw with three wait cycles in MEMWR.
        step("sw_fetch",   1'b0, OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("sw_decode",  1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_DECODE);
        step("sw_memadr",  1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMADR);
        step("sw_wait1",   1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
        step("sw_wait2",   1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
        step("sw_wait3",   1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
        step("sw_done",    1'b0, OP_SW, 6'd0, 1'b0, 1'b1, E_MEMWR);

        // FETCH stall, then R-type sub.
        step("r_stall",    1'b0, OP_R, FN_SB, 1'b0, 1'b0, E_FETCH0);
        step("r_fetch",    1'b0, OP_R, FN_SB, 1'b0, 1'b1, E_FETCH1);
        step("r_decode",   1'b0, OP_R, FN_SB, 1'b0, 1'b1, E_DECODE);
        step("r_exec_sub", 1'b0, OP_R, FN_SB, 1'b0, 1'b1, E_EXSUB);
        step("r_aluwb",    1'b0, OP_R, FN_SB, 1'b0, 1'b1, E_ALUWB);

        // R-type with unsupported funct traps back to FETCH.
        step("rx_fetch",   1'b0, OP_R, FN_XX, 1'b0, 1'b1, E_FETCH1);
        step("rx_decode",  1'b0, OP_R, FN_XX, 1'b0, 1'b1, E_DECODE);
        step("rx_exec",    1'b0, OP_R, FN_XX, 1'b0, 1'b1, E_EXILL);

        // beq taken and not taken.
        step("bq1_fetch",  1'b0, OP_BQ, 6'd0, 1'b1, 1'b1, E_FETCH1);
        step("bq1_decode", 1'b0, OP_BQ, 6'd0, 1'b1, 1'b1, E_DECODE);
        step("bq1_branch", 1'b0, OP_BQ, 6'd0, 1'b1, 1'b1, E_BEQ_Z1);
        step("bq0_fetch",  1'b0, OP_BQ, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("bq0_decode", 1'b0, OP_BQ, 6'd0, 1'b0, 1'b1, E_DECODE);
        step("bq0_branch", 1'b0, OP_BQ, 6'd0, 1'b0, 1'b1, E_BEQ_Z0);

        // Illegal opcode: one-cycle pulse, then FETCH.
        step("ill_fetch",  1'b0, OP_XX, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("ill_decode", 1'b0, OP_XX, 6'd0, 1'b0, 1'b1, E_DECILL);

        // Jump.
        step("j_fetch",    1'b0, OP_J, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("j_decode",   1'b0, OP_J, 6'd0, 1'b0, 1'b1, E_DECODE);
        step("j_jump",     1'b0, OP_J, 6'd0, 1'b0, 1'b1, E_JUMP);

        // addi.
        step("ai_fetch",   1'b0, OP_AI, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("ai_decode",  1'b0, OP_AI, 6'd0, 1'b0, 1'b1, E_DECODE);
        step("ai_exec",    1'b0, OP_AI, 6'd0, 1'b0, 1'b1, E_ADDIEX);
        step("ai_wb",      1'b0, OP_AI, 6'd0, 1'b0, 1'b1, E_ADDIWB);

        // Reset asserted in the middle of a MEMWR wait.
        step("rs_fetch",   1'b0, OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("rs_decode",  1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_DECODE);
        step("rs_memadr",  1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMADR);
        step("rs_memwr",   1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_MEMWR);
        step("rs_reset",   1'b1, OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH0);
        step("rs_rel0",    1'b0, OP_SW, 6'd0, 1'b0, 1'b0, E_FETCH0);
        step("rs_rel1",    1'b0, OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH1);
        step("rs_decode2", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, E_DECODE);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit of the multicycle MIPS datapath.
- Moore FSM decodes opcode/funct from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Produces the write enables (pcen, irwrite, regwrite, memwrite) that drive the datapath's enable-flops, plus all mux selects and ALU control.
- Stalls on a memory ready handshake.

Parameters:
- p_funct_check, 1, when 1 an unsupported R-type funct raises illegal_op; when 0 it executes as add.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- memwrite  out  1  data memory write strobe
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback select: 1=Data register
- regdst  out  1  1=rd, 0=rt
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse on an unsupported opcode/funct
- state_dbg  out  4  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 unreachable and map to FETCH.
- Reset (async): state <= FETCH. While reset is high, pcen, irwrite, regwrite, memwrite and illegal_op are forced 0. All other outputs take their FETCH values.
- Outputs are a pure function of state, plus zero and mem_ready where noted. Unlisted outputs are 0; alucontrol defaults to add.
- FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00, add.
  - irwrite = pcen = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, add (branch target computed into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other op -> FETCH, with illegal_op=1 this cycle
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 held until the mem_ready=1 cycle inclusive, then -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct: illegal_op=1 and -> FETCH when p_funct_check=1; add when p_funct_check=0
  - otherwise -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero -> FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Invariants:
  - pcen, irwrite, regwrite and memwrite are never asserted outside the states listed above.
  - At most one of regwrite/memwrite is high in any cycle.
- Latencies with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- Reset asserted mid-instruction: next state is FETCH immediately (async). No regwrite/memwrite is issued after reset asserts.

Test Plan:
- Reset pulse mid-MEMWR (memwrite=1) -> memwrite drops in the same cycle; after release, state_dbg=0 and irwrite=pcen=mem_ready.
- lw (op=100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; irwrite high only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH; regwrite never asserted.
- R-type funct=100010 -> alucontrol=110 in EXECUTE, then ALUWB with regdst=1. With funct=000111 and p_funct_check=1 -> illegal_op pulse, return to FETCH, no regwrite.
- beq: zero=1 -> pcen=1 and pcsrc=01 in BRANCH; zero=0 -> pcen=0; both take 3 cycles total.
- op=111111 in DECODE -> illegal_op=1 for exactly one cycle, next state 0. j (000010) -> pcsrc=10, pcen=1 in state 11.
